mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped console transmitter on the core's data-memory port, in the region MADDR[31:20] == 12'h001.
- Responds to core stores (DMWE) and loads (DMRE).
- Buffers store bytes in a FIFO and serializes them on a UART TX line (8N1, LSB first).
- Gives firmware a visible output path, so the console no longer depends on bench-side store snooping.

Parameters:
- FIFO_DEPTH, 16: TX FIFO entries; power of two, 2..256.
- DIV_RESET, 16'd434: reset value of the baud divisor (clocks per bit).
- BASE_HI, 12'h001: value of MADDR[31:20] that selects this block.

Ports:
- CLK  in  1  core clock; all state on posedge CLK.
- RSTN  in  1  asynchronous active-low reset.
- MADDR  in  32  word address from the core.
- DMWE  in  4  byte write enables, one per lane.
- DMRE  in  1  load strobe.
- WDATA  in  32  store data (RF_DATA2).
- RDATA  out  32  registered read data; zero when not selected.
- TXD  out  1  serial output; idle high.
- TX_IRQ  out  1  level: FIFO empty and shifter idle.

Behaviour:
- Select: sel = (MADDR[31:20] == BASE_HI). Register is chosen by MADDR[1:0].
  - 0 TXDATA, W: write with DMWE[0] pushes WDATA[7:0]. Other lanes are ignored.
  - 1 STATUS, R:
    - bit0 full, bit1 empty, bit2 busy (shifter active), bit3 overflow (sticky).
    - bits[15:8] FIFO count; all other bits 0.
  - 2 DIVISOR, RW, bits[15:0]. DMWE[0] writes [7:0]; DMWE[1] writes [15:8].
  - 3 reserved: reads 0, writes ignored.
- Read latency: RDATA is valid exactly 1 cycle after the DMRE/sel cycle. Otherwise RDATA = 0.
- Reading STATUS clears overflow in the same edge that captures RDATA, so RDATA shows the pre-clear value.
- Push to a full FIFO: the data is dropped, overflow is set, and the FIFO is unchanged.
- Push and pop in the same cycle: allowed, including when full; count is unchanged. A push to a full FIFO that coincides with a pop is accepted.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- FSM states:
  - IDLE: TXD = 1. When the FIFO is non-empty, pop to the shift register, latch the divisor into the bit counter, and go to START.
  - START: TXD = 0 for one bit time, then DATA.
  - DATA: 8 bits LSB first, each one bit time, bit index 0..7, then STOP.
  - STOP: TXD = 1 for one bit time, then IDLE. A FIFO pop can happen on the next cycle, so the gap between frames is at least 1 clock.
- Bit time = divisor clocks. The divisor is latched at frame start, so a mid-frame DIVISOR write takes effect from the next frame. A latched value of 0 is treated as 1.
- busy = state != IDLE.
- Reset, asynchronous: state IDLE, TXD 1, RDATA 0, FIFO empty, overflow 0, divisor DIV_RESET, TX_IRQ 1. A reset mid-frame aborts the frame, and TXD returns high immediately.
- Accesses outside the region have no effect.

Decomposition:
- Shared package/header (riscv.vh): MMIO_BASE_HI, register offsets (REG_TXDATA = 0, REG_STATUS = 1, REG_DIVISOR = 2), and STATUS bit positions.
- One natural sub-module: sync_fifo (parameter width 8, depth FIFO_DEPTH) with push, pop, full, empty and count.
- The FSM and decode live in the top.

Test Plan:
- Reset defaults: assert RSTN = 0 mid-frame → TXD = 1 immediately. STATUS read returns 32'h0000_0002 and TX_IRQ = 1.
- Single byte, DIVISOR = 4: store 32'h0000_0041 to 0x0010_0000 →
  - TXD pattern 0,1,0,0,0,0,0,1,0,1, each bit 4 clocks, 40 clocks total.
  - busy = 1 during the frame; TX_IRQ = 1 after it.
- Overflow, DIVISOR = 1000, FIFO_DEPTH = 16: push 18 bytes 0x00..0x11 back to back.
  - The first byte pops at once, so 16 more fit and the 18th (0x11) is dropped.
  - STATUS shows full and overflow. A second STATUS read shows overflow = 0.
  - Serial output is 0x00..0x10 in order.
- Divisor change mid-frame: set DIVISOR = 8, send 0x55. During DATA, write DIVISOR = 2 →
  - the current frame keeps 8 clocks per bit;
  - the next frame uses 2 clocks per bit.
- Lane and decode: store with DMWE = 4'b1110 to TXDATA → no push. Store 0x12345678 to 0x0020_0000 → no effect. A read from 0x0020_0000 gives RDATA = 0.
- Full with simultaneous pop: fill the FIFO, then push at the exact cycle the FSM pops → byte accepted, count stays 16, overflow stays 0.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx shared definitions.
// Register map, STATUS bit layout and TX FSM states.
package mmio_uart_tx_pkg;

    localparam logic [11:0] MMIO_BASE_HI = 12'h001;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    // A divisor of 0 would stall the bit counter; run it as 1.
    function automatic logic [15:0] div_eff(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx data-memory port bundle.
// Core side drives address/strobes, the device returns RDATA.
interface mmio_uart_tx_if;

    logic [31:0] MADDR;
    logic [3:0]  DMWE;
    logic        DMRE;
    logic [31:0] WDATA;
    logic [31:0] RDATA;

    modport master (
        output MADDR,
        output DMWE,
        output DMRE,
        output WDATA,
        input  RDATA
    );

    modport slave (
        input  MADDR,
        input  DMWE,
        input  DMRE,
        input  WDATA,
        output RDATA
    );

endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// mmio_uart_tx byte FIFO.
// Push to a full FIFO is accepted only when a pop happens in the same cycle.
module mmio_uart_tx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    // Storage: no reset needed, validity is tracked by count.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped console transmitter.
// Store bytes are queued and sent 8N1, LSB first, on TXD.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd434,
    parameter logic [11:0] BASE_HI    = MMIO_BASE_HI
) (
    input  logic          CLK,
    input  logic          RSTN,
    mmio_uart_tx_if.slave bus,
    output logic          TXD,
    output logic          TX_IRQ
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    reg_a;
    logic          wr_tx;
    logic          wr_div_lo;
    logic          wr_div_hi;
    logic          rd;
    logic          is_stat;
    logic          is_div;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    fifo_q;
    logic [8:0]    cnt9;
    logic [7:0]    cnt8;
    logic          busy;
    logic          ovf;
    logic [15:0]   divisor;
    logic [31:0]   status;
    logic [31:0]   rd_val;

    tx_state_e   state;
    tx_state_e   state_n;
    logic [7:0]  shreg;
    logic [7:0]  shreg_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [2:0]  bidx;
    logic [2:0]  bidx_n;
    logic [15:0] div_lat;
    logic [15:0] div_lat_n;
    logic        tick;

    logic unused;
    assign unused = ^{bus.MADDR[19:2], bus.DMWE[3:2], bus.WDATA[31:16]};

    assign sel       = (bus.MADDR[31:20] == BASE_HI);
    assign reg_a     = bus.MADDR[1:0];
    assign is_stat   = (reg_a == REG_STATUS);
    assign is_div    = (reg_a == REG_DIVISOR);
    assign wr_tx     = sel && bus.DMWE[0] && (reg_a == REG_TXDATA);
    assign wr_div_lo = sel && bus.DMWE[0] && is_div;
    assign wr_div_hi = sel && bus.DMWE[1] && is_div;
    assign rd        = sel && bus.DMRE;

    assign busy   = (state != S_IDLE);
    assign TX_IRQ = empty && !busy;
    assign tick   = (cnt == 16'd1);

    mmio_uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .push  (wr_tx),
        .pop   (pop),
        .din   (bus.WDATA[7:0]),
        .dout  (fifo_q),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // STATUS image; a count of 256 saturates the 8-bit field.
    always_comb begin
        status             = '0;
        cnt9               = 9'(count);
        cnt8               = cnt9[8] ? 8'hFF : cnt9[7:0];
        status[ST_FULL]    = full;
        status[ST_EMPTY]   = empty;
        status[ST_BUSY]    = busy;
        status[ST_OVF]     = ovf;
        status[ST_CNT +: 8] = cnt8;
    end

    // Read mux; TXDATA and the reserved slot read as zero.
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            is_stat: rd_val = status;
            is_div:  rd_val = {16'h0, divisor};
            default: rd_val = '0;
        endcase
    end

    // Registered read data, zero on any cycle without a selected load.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            bus.RDATA <= '0;
        end else begin
            bus.RDATA <= rd ? rd_val : '0;
        end
    end

    // Sticky overflow, cleared by the same edge that captures STATUS.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ovf <= 1'b0;
        end else if (wr_tx && full && !pop) begin
            ovf <= 1'b1;
        end else if (rd && is_stat) begin
            ovf <= 1'b0;
        end
    end

    // Baud divisor, byte-lane writable.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            divisor <= DIV_RESET;
        end else begin
            if (wr_div_lo) begin
                divisor[7:0] <= bus.WDATA[7:0];
            end
            if (wr_div_hi) begin
                divisor[15:8] <= bus.WDATA[15:8];
            end
        end
    end

    // TX state register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= S_IDLE;
            shreg   <= '0;
            cnt     <= 16'd1;
            bidx    <= '0;
            div_lat <= div_eff(DIV_RESET);
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            bidx    <= bidx_n;
            div_lat <= div_lat_n;
        end
    end

    // TX next state, FIFO pop and line level.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        cnt_n     = cnt;
        bidx_n    = bidx;
        div_lat_n = div_lat;
        pop       = 1'b0;
        TXD       = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_n   = fifo_q;
                    div_lat_n = div_eff(divisor);
                    cnt_n     = div_eff(divisor);
                    bidx_n    = '0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                TXD = 1'b0;
                if (tick) begin
                    cnt_n   = div_lat;
                    state_n = S_DATA;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            S_DATA: begin
                TXD = shreg[0];
                if (tick) begin
                    cnt_n   = div_lat;
                    shreg_n = {1'b0, shreg[7:1]};
                    bidx_n  = bidx + 3'd1;
                    if (bidx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// mmio_uart_tx testbench.
// Directed steps with hand-computed expectations.
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TX   = 32'h0010_0000;
    localparam logic [31:0] A_ST   = 32'h0010_0001;
    localparam logic [31:0] A_DIV  = 32'h0010_0002;
    localparam logic [31:0] A_RSV  = 32'h0010_0003;

    logic CLK;
    logic RSTN;
    logic TXD;
    logic TX_IRQ;
    int   tests;
    int   fails;
    int   cyc;

    mmio_uart_tx_if bus ();

    mmio_uart_tx dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .bus    (bus),
        .TXD    (TXD),
        .TX_IRQ (TX_IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] we);
        bus.MADDR = a;
        bus.WDATA = d;
        bus.DMWE  = we;
        @(negedge CLK);
        bus.MADDR = '0;
        bus.WDATA = '0;
        bus.DMWE  = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        bus.MADDR = a;
        bus.DMRE  = 1'b1;
        @(negedge CLK);
        q = bus.RDATA;
        bus.MADDR = '0;
        bus.DMRE  = 1'b0;
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic check_frame(input logic [7:0] b, input int div,
                               input int first);
        for (int i = first; i < 10 * div; i++) begin
            chk(32'(TXD), 32'(fbit(b, i / div)),
                $sformatf("frame_%02h_c%0d", b, i));
            @(negedge CLK);
        end
    endtask

    task automatic rx_byte(input int div, output logic [7:0] b);
        int n;
        n = 0;
        b = '0;
        while (TXD !== 1'b0 && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        chk(32'(n < 20000), 32'd1, "rx_start_wait");
        repeat (div / 2) @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
            repeat (div) @(negedge CLK);
            b[k] = TXD;
        end
        repeat (div) @(negedge CLK);
        chk(32'(TXD), 32'd1, "rx_stop_bit");
        repeat (div - div / 2) @(negedge CLK);
    endtask

    initial begin
        logic [31:0] q;
        logic [7:0]  b;
        int          s0;
        int          n;
        tests = 0;
        fails = 0;
        bus.MADDR = '0;
        bus.WDATA = '0;
        bus.DMWE  = '0;
        bus.DMRE  = 1'b0;
        RSTN = 1'b0;
        repeat (3) @(negedge CLK);
        chk(32'(TXD), 32'd1, "rst_txd");
        chk(32'(TX_IRQ), 32'd1, "rst_irq");
        chk(bus.RDATA, 32'h0, "rst_rdata");
        RSTN = 1'b1;
        @(negedge CLK);

        rd(A_ST, q);
        chk(q, 32'h0000_0002, "rst_status");
        @(negedge CLK);
        chk(bus.RDATA, 32'h0, "rdata_idle_zero");
        rd(A_DIV, q);
        chk(q, 32'h0000_01B2, "rst_divisor");

        wr(A_DIV, 32'd4, 4'b0011);
        rd(A_DIV, q);
        chk(q, 32'd4, "div_write");
        wr(A_TX, 32'h0000_0041, 4'b0001);
        chk(32'(TX_IRQ), 32'd0, "irq_pending");
        @(negedge CLK);
        check_frame(8'h41, 4, 0);
        chk(32'(TX_IRQ), 32'd1, "irq_after_frame");
        chk(32'(TXD), 32'd1, "txd_idle_after");

        wr(A_TX, 32'h0000_00FF, 4'b1110);
        rd(A_ST, q);
        chk(q, 32'h0000_0002, "lane_no_push");
        wr(32'h0020_0000, 32'h1234_5678, 4'b1111);
        wr(32'h0020_0002, 32'h1234_5678, 4'b1111);
        rd(32'h0020_0000, q);
        chk(q, 32'h0, "out_of_region_rd0");
        rd(32'h0020_0001, q);
        chk(q, 32'h0, "out_of_region_rd1");
        rd(A_ST, q);
        chk(q, 32'h0000_0002, "out_of_region_status");
        rd(A_DIV, q);
        chk(q, 32'd4, "out_of_region_div");
        wr(A_RSV, 32'hFFFF_FFFF, 4'b1111);
        rd(A_RSV, q);
        chk(q, 32'h0, "reserved_rd");
        wr(A_DIV, 32'h0000_0800, 4'b0010);
        rd(A_DIV, q);
        chk(q, 32'h0000_0804, "div_hi_lane");

        wr(A_DIV, 32'd8, 4'b0011);
        wr(A_TX, 32'h0000_0055, 4'b0001);
        @(negedge CLK);
        for (int i = 0; i < 80; i++) begin
            chk(32'(TXD), 32'(fbit(8'h55, i / 8)),
                $sformatf("frame_55_c%0d", i));
            case (i)
                16: begin
                    bus.MADDR = A_DIV;
                    bus.WDATA = 32'd2;
                    bus.DMWE  = 4'b0011;
                end
                18: begin
                    bus.MADDR = A_TX;
                    bus.WDATA = 32'h0000_00A3;
                    bus.DMWE  = 4'b0001;
                end
                20: begin
                    bus.MADDR = A_ST;
                    bus.DMRE  = 1'b1;
                end
                21: begin
                    chk(bus.RDATA, 32'h0000_0104, "busy_status");
                    bus.MADDR = '0;
                    bus.DMRE  = 1'b0;
                end
                default: begin
                    bus.MADDR = bus.DMRE ? bus.MADDR : '0;
                    bus.WDATA = '0;
                    bus.DMWE  = '0;
                end
            endcase
            @(negedge CLK);
        end
        chk(32'(TXD), 32'd1, "gap_idle_txd");
        chk(32'(TX_IRQ), 32'd0, "gap_irq");
        @(negedge CLK);
        check_frame(8'hA3, 2, 0);
        chk(32'(TX_IRQ), 32'd1, "irq_after_a3");

        wr(A_DIV, 32'd1000, 4'b0011);
        s0 = 0;
        for (int k = 0; k < 18; k++) begin
            wr(A_TX, 32'(k), 4'b0001);
            if (k == 1) s0 = cyc;
        end
        rd(A_ST, q);
        chk(q, 32'h0000_100D, "ovf_status");
        rd(A_ST, q);
        chk(q, 32'h0000_1005, "ovf_cleared");
        wr(A_DIV, 32'd0, 4'b0011);
        chk(32'(TXD), 32'd0, "ovf_in_frame");
        n = 0;
        while (TXD === 1'b0 && n < 12000) begin
            @(negedge CLK);
            n++;
        end
        chk(32'(cyc - s0), 32'd9000, "frame00_low_len");
        for (int k = 1; k <= 16; k++) begin
            rx_byte(1, b);
            chk(32'(b), 32'(k), $sformatf("ovf_rx_%0d", k));
        end
        chk(32'(TX_IRQ), 32'd1, "ovf_drained_irq");
        rd(A_ST, q);
        chk(q, 32'h0000_0002, "ovf_drained_status");

        wr(A_DIV, 32'd2, 4'b0011);
        for (int k = 0; k < 17; k++) begin
            wr(A_TX, 32'h80 + 32'(k), 4'b0001);
        end
        repeat (5) @(negedge CLK);
        wr(A_TX, 32'h0000_0091, 4'b0001);
        rd(A_ST, q);
        chk(q, 32'h0000_1005, "full_push_pop");
        check_frame(8'h81, 2, 1);
        for (int k = 2; k <= 17; k++) begin
            rx_byte(2, b);
            chk(32'(b), 32'h80 + 32'(k), $sformatf("full_rx_%0d", k));
        end
        chk(32'(TX_IRQ), 32'd1, "full_drained_irq");

        wr(A_TX, 32'h0000_0000, 4'b0001);
        @(negedge CLK);
        chk(32'(TXD), 32'd0, "pre_rst_start");
        #2 RSTN = 1'b0;
        #1;
        chk(32'(TXD), 32'd1, "rst_mid_txd");
        chk(32'(TX_IRQ), 32'd1, "rst_mid_irq");
        chk(bus.RDATA, 32'h0, "rst_mid_rdata");
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        rd(A_ST, q);
        chk(q, 32'h0000_0002, "post_rst_status");
        rd(A_DIV, q);
        chk(q, 32'h0000_01B2, "post_rst_div");
        repeat (5) @(negedge CLK);
        chk(32'(TXD), 32'd1, "post_rst_txd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
